rv_sb_reg_file: RTL and testbench
=================================

Name: rv_sb_reg_file

Overview:
- Parametrised integer register file with multiple read/write ports, an integrated pending-write scoreboard and optional write-to-read bypass.
- Each register has a saturating pending counter instead of a single in-use bit, so multiple in-flight writers to the same register can be tracked by the out-of-order/multi-issue backend.
- Sits between decode/issue (allocation, operand read) and writeback; register 0 reads as zero and is never busy.

Parameters:
- NUM_REGS, 32, number of architectural registers (power of two, >=2); AW = $clog2(NUM_REGS).
- DATA_WIDTH, 32, register width in bits.
- NUM_RPORTS, 2, number of read ports.
- NUM_WPORTS, 2, number of writeback ports.
- NUM_APORTS, 1, number of destination-allocation ports.
- PEND_W, 2, pending counter width; max outstanding writers per register = 2^PEND_W-1.
- BYPASS, 1, 1 = same-cycle writeback forwarded to reads and busy; 0 = registered only.

Ports:
- CLK  input  1  clock, rising edge.
- nRST  input  1  reset, asynchronous, active-low.
- raddr  input  NUM_RPORTS*AW  read addresses, port i at [i*AW +: AW].
- rdata  output  NUM_RPORTS*DATA_WIDTH  read data.
- rbusy  output  NUM_RPORTS  register has an outstanding writer.
- wen  input  NUM_WPORTS  writeback valid.
- waddr  input  NUM_WPORTS*AW  writeback address.
- wdata  input  NUM_WPORTS*DATA_WIDTH  writeback data.
- alloc_en  input  NUM_APORTS  reserve destination (increment pending).
- alloc_addr  input  NUM_APORTS*AW  destination register.
- alloc_ready  output  NUM_APORTS  allocation accepted this cycle.
- flush  input  1  clear all pending counters (pipeline squash).
- pend_err  output  1  sticky: writeback to a register with zero pending.

Behaviour:
- Reset: all registers 0, all counters 0, pend_err 0. Combinational outputs follow from reset state: rdata 0, rbusy 0, alloc_ready all 1.
- Write: on a rising edge with wen[j] and waddr[j]!=0, the register takes wdata[j]. If several ports write the same register in one cycle, the highest index j wins the data.
- Register 0: writes to it are ignored, reads return 0, rbusy is 0, and alloc to it is a no-op with alloc_ready=1.
- Pending counter, per register r each cycle: next = pend[r] + A[r] - W[r], where A = accepted allocs to r and W = wen ports targeting r.
- Pending saturation: an alloc to r is accepted (alloc_ready[k]=1) only if pend[r] + (accepted lower-index allocs to r) + 1 <= 2^PEND_W-1. Current-cycle writebacks are not credited. Rejected allocs leave state unchanged.
- Pending underflow: if W[r] > pend[r] + A[r], the counter clamps to 0 and pend_err sets and stays set until reset. The data write still occurs.
- Flush: all counters go to 0 next cycle, and allocs and writeback decrements in that cycle are ignored. Data writes in the flush cycle still commit, and pend_err is not set by them.
- Read, BYPASS=0: rdata = registered value. rbusy = pend[raddr]!=0.
- Read, BYPASS=1: if any wen targets raddr (nonzero), rdata = the highest-index such wdata. rbusy = (pend[raddr] - W[raddr]) > 0, with allocs in the same cycle not considered.
- Latency: reads are combinational. A write is visible next cycle (BYPASS=0) or same cycle (BYPASS=1). Alloc makes rbusy true from the next cycle.
- alloc_ready is combinational from the current counters and alloc_en/alloc_addr only; no dependence on wen, to avoid loops.
- Reset asserted mid-operation clears everything immediately, independent of CLK.

Decomposition:
- Package rv_regfile_pkg: regfile params struct defaults, typedefs regidx_t (logic [AW-1:0]) and pend_t, and constant PEND_MAX.
- Sub-module rv_pend_counter (one per register): inputs inc_cnt, dec_cnt, flush; outputs count, nonzero and an underflow pulse. Saturation/accept logic stays in the top level.

Test Plan:
- Reset, then read all 32 registers on both ports -> rdata=0, rbusy=0, alloc_ready=1, pend_err=0.
- Alloc x5, next cycle read x5 -> rbusy=1. Then wen0 x5=0xDEADBEEF -> with BYPASS=1 same cycle rdata=0xDEADBEEF, rbusy=0. Next cycle the counter is 0.
- Alloc x7 three times (PEND_W=2) -> pend=3. Fourth alloc -> alloc_ready=0, pend stays 3. Three writebacks -> rbusy clears only after the third.
- Same-cycle wen0 and wen1 to x9 with 0x11/0x22 and pend=2 -> x9=0x22, pend=0, pend_err=0.
- wen to x3 with pend=0 -> x3 written, pend stays 0, pend_err=1 and it stays 1 through further traffic until nRST.
- Alloc x4, x6 then flush together with a wen to x4=0x55 -> all rbusy=0 next cycle, x4=0x55, pend_err=0. Write/alloc to x0 -> reads 0, never busy.

Source files
------------

// File: rtl/rv_sb_reg_file_pkg.sv
// Shared configuration defaults and types for the scoreboarded register file.
// Widths here describe the default build; instances derive their own widths from parameters.
package rv_regfile_pkg;

  typedef struct packed {
    int num_regs;
    int data_width;
    int num_rports;
    int num_wports;
    int num_aports;
    int pend_w;
    int bypass;
  } rf_cfg_t;

  localparam rf_cfg_t RF_DEFAULTS = '{
    num_regs:   32,
    data_width: 32,
    num_rports: 2,
    num_wports: 2,
    num_aports: 1,
    pend_w:     2,
    bypass:     1
  };

  localparam int RF_AW     = $clog2(RF_DEFAULTS.num_regs);
  localparam int RF_PEND_W = RF_DEFAULTS.pend_w;
  localparam int PEND_MAX  = (1 << RF_PEND_W) - 1;

  typedef logic [RF_AW-1:0]     regidx_t;
  typedef logic [RF_PEND_W-1:0] pend_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rv_sb_reg_file_if.sv
// Operand read, writeback and allocation bundle between issue/writeback and the register file.
// master = pipeline side, slave = register file side.
interface rv_sb_reg_file_if
  import rv_regfile_pkg::*;
#(
  parameter int NUM_REGS   = RF_DEFAULTS.num_regs,
  parameter int DATA_WIDTH = RF_DEFAULTS.data_width,
  parameter int NUM_RPORTS = RF_DEFAULTS.num_rports,
  parameter int NUM_WPORTS = RF_DEFAULTS.num_wports,
  parameter int NUM_APORTS = RF_DEFAULTS.num_aports
) ();
  localparam int AW = $clog2(NUM_REGS);

  logic [NUM_RPORTS*AW-1:0]         raddr;
  logic [NUM_RPORTS*DATA_WIDTH-1:0] rdata;
  logic [NUM_RPORTS-1:0]            rbusy;
  logic [NUM_WPORTS-1:0]            wen;
  logic [NUM_WPORTS*AW-1:0]         waddr;
  logic [NUM_WPORTS*DATA_WIDTH-1:0] wdata;
  logic [NUM_APORTS-1:0]            alloc_en;
  logic [NUM_APORTS*AW-1:0]         alloc_addr;
  logic [NUM_APORTS-1:0]            alloc_ready;
  logic                             flush;
  logic                             pend_err;

  modport master (
    output raddr, wen, waddr, wdata, alloc_en, alloc_addr, flush,
    input  rdata, rbusy, alloc_ready, pend_err
  );

  modport slave (
    input  raddr, wen, waddr, wdata, alloc_en, alloc_addr, flush,
    output rdata, rbusy, alloc_ready, pend_err
  );
endinterface

// File: rtl/rv_sb_reg_file_pend_counter.sv
// Per-register outstanding-writer counter: adds accepted allocs, subtracts writebacks, clamps at 0.
// One-cycle update; flush zeroes it and suppresses the underflow pulse.
module rv_pend_counter
  import rv_regfile_pkg::*;
#(
  parameter int PEND_W = RF_PEND_W,
  parameter int CW     = 2
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [CW-1:0]     inc_cnt,
  input  logic [CW-1:0]     dec_cnt,
  input  logic              flush,
  output logic [PEND_W-1:0] count,
  output logic              nonzero,
  output logic              underflow
);
  localparam int            SW  = PEND_W + CW;
  localparam logic [SW-1:0] SAT = SW'((1 << PEND_W) - 1);

  logic [SW-1:0]     sum;
  logic [SW-1:0]     dec_ext;
  logic [SW-1:0]     diff;
  logic [PEND_W-1:0] count_d;

  always_comb begin
    sum       = {{CW{1'b0}}, count} + {{PEND_W{1'b0}}, inc_cnt};
    dec_ext   = {{PEND_W{1'b0}}, dec_cnt};
    diff      = sum - dec_ext;
    underflow = 1'b0;
    count_d   = count;
    if (flush) begin
      count_d = '0;
    end else if (dec_ext > sum) begin
      underflow = 1'b1;
      count_d   = '0;
    end else if (diff > SAT) begin
      // Unreachable while the top-level accept logic is honoured; keeps the counter from wrapping.
      count_d = SAT[PEND_W-1:0];
    end else begin
      count_d = diff[PEND_W-1:0];
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      count <= '0;
    end else begin
      count <= count_d;
    end
  end

  assign nonzero = |count;

endmodule

// File: rtl/rv_sb_reg_file.sv
// Multi-port integer register file with saturating pending-writer scoreboard and optional bypass.
// Reads and alloc_ready are combinational; alloc_ready drops when a register's counter would saturate.
module rv_sb_reg_file
  import rv_regfile_pkg::*;
#(
  parameter int NUM_REGS   = RF_DEFAULTS.num_regs,
  parameter int DATA_WIDTH = RF_DEFAULTS.data_width,
  parameter int NUM_RPORTS = RF_DEFAULTS.num_rports,
  parameter int NUM_WPORTS = RF_DEFAULTS.num_wports,
  parameter int NUM_APORTS = RF_DEFAULTS.num_aports,
  parameter int PEND_W     = RF_DEFAULTS.pend_w,
  parameter int BYPASS     = RF_DEFAULTS.bypass
) (
  input logic             CLK,
  input logic             nRST,
  rv_sb_reg_file_if.slave bus
);
  localparam int AW   = $clog2(NUM_REGS);
  localparam int DW   = DATA_WIDTH;
  localparam int PMAX = (1 << PEND_W) - 1;
  localparam int CW   = $clog2(max_int(NUM_APORTS, NUM_WPORTS) + 1);
  localparam int SW   = PEND_W + CW;

  logic [DW-1:0]     regs_q [NUM_REGS];
  logic [PEND_W-1:0] pend   [NUM_REGS];
  logic              nz     [NUM_REGS];
  logic              uf     [NUM_REGS];
  logic [CW-1:0]     acnt   [NUM_REGS];
  logic [CW-1:0]     wcnt   [NUM_REGS];

  logic [AW-1:0] alloc_idx;
  logic [SW-1:0] alloc_sum;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;
  logic          any_uf;

  // Entry 0 is reset and never written, so it reads as zero without a mux.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
    end else begin
      for (int j = 0; j < NUM_WPORTS; j++) begin
        if (bus.wen[j] && (bus.waddr[j*AW +: AW] != '0)) begin
          regs_q[bus.waddr[j*AW +: AW]] <= bus.wdata[j*DW +: DW];
        end
      end
    end
  end

  // Lower-index accepted allocs to the same register count against the headroom of later ones.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) acnt[r] = '0;
    alloc_idx       = '0;
    alloc_sum       = '0;
    bus.alloc_ready = '1;
    for (int k = 0; k < NUM_APORTS; k++) begin
      alloc_idx = bus.alloc_addr[k*AW +: AW];
      alloc_sum = {{CW{1'b0}}, pend[alloc_idx]} + {{PEND_W{1'b0}}, acnt[alloc_idx]};
      if (alloc_idx != '0) begin
        bus.alloc_ready[k] = alloc_sum < SW'(PMAX);
        if (bus.alloc_en[k] && bus.alloc_ready[k]) begin
          acnt[alloc_idx] = acnt[alloc_idx] + CW'(1);
        end
      end
    end
  end

  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) wcnt[r] = '0;
    wr_idx = '0;
    for (int j = 0; j < NUM_WPORTS; j++) begin
      wr_idx = bus.waddr[j*AW +: AW];
      if (bus.wen[j] && (wr_idx != '0)) begin
        wcnt[wr_idx] = wcnt[wr_idx] + CW'(1);
      end
    end
  end

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_cnt
    if (r == 0) begin : g_zero
      assign pend[r] = '0;
      assign nz[r]   = 1'b0;
      assign uf[r]   = 1'b0;
    end else begin : g_ctr
      rv_pend_counter #(
        .PEND_W (PEND_W),
        .CW     (CW)
      ) u_cnt (
        .CLK       (CLK),
        .nRST      (nRST),
        .inc_cnt   (acnt[r]),
        .dec_cnt   (wcnt[r]),
        .flush     (bus.flush),
        .count     (pend[r]),
        .nonzero   (nz[r]),
        .underflow (uf[r])
      );
    end
  end

  // With bypass, writebacks landing this cycle retire their pending slot early; allocs do not count yet.
  always_comb begin
    bus.rdata = '0;
    bus.rbusy = '0;
    rd_idx    = '0;
    for (int i = 0; i < NUM_RPORTS; i++) begin
      rd_idx = bus.raddr[i*AW +: AW];
      bus.rdata[i*DW +: DW] = regs_q[rd_idx];
      for (int j = 0; j < NUM_WPORTS; j++) begin
        if ((BYPASS != 0) && bus.wen[j] && (rd_idx != '0) &&
            (bus.waddr[j*AW +: AW] == rd_idx)) begin
          bus.rdata[i*DW +: DW] = bus.wdata[j*DW +: DW];
        end
      end
      bus.rbusy[i] = nz[rd_idx] &&
                     ((BYPASS == 0) ||
                      ({{CW{1'b0}}, pend[rd_idx]} > {{PEND_W{1'b0}}, wcnt[rd_idx]}));
    end
  end

  always_comb begin
    any_uf = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) any_uf = any_uf | uf[r];
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      bus.pend_err <= 1'b0;
    end else if (any_uf) begin
      bus.pend_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rv_sb_reg_file.sv
// Directed vector bench for rv_sb_reg_file in its default build (32 x 32b, 2R/2W/1A, PEND_W=2, bypass on).
module tb_rv_sb_reg_file;
  import rv_regfile_pkg::*;

  logic CLK  = 1'b0;
  logic nRST = 1'b0;

  rv_sb_reg_file_if #(
    .NUM_REGS(32), .DATA_WIDTH(32), .NUM_RPORTS(2), .NUM_WPORTS(2), .NUM_APORTS(1)
  ) bus ();

  rv_sb_reg_file #(
    .NUM_REGS(32), .DATA_WIDTH(32), .NUM_RPORTS(2), .NUM_WPORTS(2),
    .NUM_APORTS(1), .PEND_W(2), .BYPASS(1)
  ) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus.slave)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0]  wen;
    regidx_t     wa0, wa1;
    logic [31:0] wd0, wd1;
    logic        aen;
    regidx_t     aa;
    logic        fl;
    regidx_t     ra0, ra1;
    logic [31:0] e_rd0, e_rd1;
    logic [1:0]  e_busy;
    logic        e_ardy;
    logic        e_perr;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic vec_t mk(input int wen, input int wa0, input logic [31:0] wd0,
                              input int wa1, input logic [31:0] wd1,
                              input int aen, input int aa, input int fl,
                              input int ra0, input int ra1,
                              input logic [31:0] e_rd0, input logic [31:0] e_rd1,
                              input int e_busy, input int e_ardy, input int e_perr);
    vec_t v;
    v.wen    = 2'(wen);
    v.wa0    = regidx_t'(wa0);
    v.wd0    = wd0;
    v.wa1    = regidx_t'(wa1);
    v.wd1    = wd1;
    v.aen    = 1'(aen);
    v.aa     = regidx_t'(aa);
    v.fl     = 1'(fl);
    v.ra0    = regidx_t'(ra0);
    v.ra1    = regidx_t'(ra1);
    v.e_rd0  = e_rd0;
    v.e_rd1  = e_rd1;
    v.e_busy = 2'(e_busy);
    v.e_ardy = 1'(e_ardy);
    v.e_perr = 1'(e_perr);
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus.wen        = v.wen;
    bus.waddr      = {v.wa1, v.wa0};
    bus.wdata      = {v.wd1, v.wd0};
    bus.alloc_en   = v.aen;
    bus.alloc_addr = v.aa;
    bus.flush      = v.fl;
    bus.raddr      = {v.ra1, v.ra0};
  endtask

  task automatic check(input string nm, input logic [31:0] rd0, input logic [31:0] rd1,
                       input logic [1:0] busy, input logic ardy, input logic perr);
    n_vec++;
    if (bus.rdata !== {rd1, rd0} || bus.rbusy !== busy ||
        bus.alloc_ready !== ardy || bus.pend_err !== perr) begin
      n_bad++;
      $display("FAIL %s: got rdata=%h rbusy=%b alloc_ready=%b pend_err=%b, want rdata=%h rbusy=%b alloc_ready=%b pend_err=%b",
               nm, bus.rdata, bus.rbusy, bus.alloc_ready, bus.pend_err,
               {rd1, rd0}, busy, ardy, perr);
    end
  endtask

  initial begin
    // Columns: wen wa0 wd0 wa1 wd1 | aen aa flush | ra0 ra1 | exp rd0 rd1 rbusy alloc_ready pend_err
    // x5: alloc, busy next cycle, bypassed writeback retires it
    vecs.push_back(mk(0,0,0,0,0,  1,5,0,  5,0,  0,0,2'b00,1,0));
    vecs.push_back(mk(0,0,0,0,0,  0,0,0,  5,0,  0,0,2'b01,1,0));
    vecs.push_back(mk(1,5,32'hDEADBEEF,0,0, 0,0,0, 5,0, 32'hDEADBEEF,0,2'b00,1,0));
    vecs.push_back(mk(0,0,0,0,0,  0,0,0,  5,0,  32'hDEADBEEF,0,2'b00,1,0));
    // x7: three allocs fill the counter, fourth rejected, three writebacks drain it
    vecs.push_back(mk(0,0,0,0,0,  1,7,0,  7,0,  0,0,2'b00,1,0));
    vecs.push_back(mk(0,0,0,0,0,  1,7,0,  7,0,  0,0,2'b01,1,0));
    vecs.push_back(mk(0,0,0,0,0,  1,7,0,  7,0,  0,0,2'b01,1,0));
    vecs.push_back(mk(0,0,0,0,0,  1,7,0,  7,0,  0,0,2'b01,0,0));
    vecs.push_back(mk(1,7,32'h70,0,0, 0,0,0, 7,0, 32'h70,0,2'b01,1,0));
    vecs.push_back(mk(1,7,32'h71,0,0, 0,0,0, 7,0, 32'h71,0,2'b01,1,0));
    vecs.push_back(mk(1,7,32'h72,0,0, 0,0,0, 7,0, 32'h72,0,2'b00,1,0));
    vecs.push_back(mk(0,0,0,0,0,  0,0,0,  7,0,  32'h72,0,2'b00,1,0));
    // x9: two pending, both write ports hit it in one cycle, port 1 wins
    vecs.push_back(mk(0,0,0,0,0,  1,9,0,  9,0,  0,0,2'b00,1,0));
    vecs.push_back(mk(0,0,0,0,0,  1,9,0,  9,0,  0,0,2'b01,1,0));
    vecs.push_back(mk(3,9,32'h11,9,32'h22, 0,0,0, 9,0, 32'h22,0,2'b00,1,0));
    vecs.push_back(mk(0,0,0,0,0,  0,0,0,  9,7,  32'h22,32'h72,2'b00,1,0));
    // flush with x4/x6 pending, a write to x4 and an unmatched write to x8
    vecs.push_back(mk(0,0,0,0,0,  1,4,0,  4,0,  0,0,2'b00,1,0));
    vecs.push_back(mk(0,0,0,0,0,  1,6,0,  4,6,  0,0,2'b01,1,0));
    vecs.push_back(mk(3,4,32'h55,8,32'h88, 1,6,1, 4,6, 32'h55,0,2'b10,1,0));
    vecs.push_back(mk(0,0,0,0,0,  0,0,0,  4,6,  32'h55,0,2'b00,1,0));
    vecs.push_back(mk(0,0,0,0,0,  0,0,0,  8,6,  32'h88,0,2'b00,1,0));
    // x0: write and alloc are no-ops
    vecs.push_back(mk(1,0,32'hFF,0,0, 1,0,0, 0,0, 0,0,2'b00,1,0));
    vecs.push_back(mk(0,0,0,0,0,  0,0,0,  0,0,  0,0,2'b00,1,0));
    // x3: writeback with nothing pending sets the sticky error; counter clamps at 0
    vecs.push_back(mk(1,3,32'h33,0,0, 0,0,0, 3,0, 32'h33,0,2'b00,1,0));
    vecs.push_back(mk(0,0,0,0,0,  0,0,0,  3,0,  32'h33,0,2'b00,1,1));
    vecs.push_back(mk(0,0,0,0,0,  1,3,0,  3,0,  32'h33,0,2'b00,1,1));
    vecs.push_back(mk(1,3,32'h34,0,0, 0,0,0, 3,0, 32'h34,0,2'b00,1,1));
    vecs.push_back(mk(0,0,0,0,0,  0,0,0,  3,0,  32'h34,0,2'b00,1,1));

    drive(mk(0,0,0,0,0, 0,0,0, 0,0, 0,0,0,0,0));
    repeat (2) @(negedge CLK);
    nRST = 1'b1;

    for (int r = 0; r < 32; r++) begin
      @(negedge CLK);
      bus.raddr = {regidx_t'(31 - r), regidx_t'(r)};
      #1;
      check($sformatf("reset_read_x%0d", r), 32'h0, 32'h0, 2'b00, 1'b1, 1'b0);
    end

    for (int k = 0; k < vecs.size(); k++) begin
      @(negedge CLK);
      drive(vecs[k]);
      #1;
      check($sformatf("vec%0d", k), vecs[k].e_rd0, vecs[k].e_rd1,
            vecs[k].e_busy, vecs[k].e_ardy, vecs[k].e_perr);
    end

    // Asynchronous reset between edges with a pending alloc and a sticky error in place
    @(negedge CLK);
    drive(mk(0,0,0,0,0, 1,12,0, 3,0, 0,0,0,0,0));
    @(negedge CLK);
    drive(mk(0,0,0,0,0, 0,0,0, 3,12, 0,0,0,0,0));
    #1;
    check("pre_reset", 32'h34, 32'h0, 2'b10, 1'b1, 1'b1);
    #2 nRST = 1'b0;
    #1;
    check("async_reset", 32'h0, 32'h0, 2'b00, 1'b1, 1'b0);
    @(negedge CLK);
    nRST = 1'b1;
    drive(mk(0,0,0,0,0, 1,12,0, 7,12, 0,0,0,0,0));
    #1;
    check("post_reset_alloc", 32'h0, 32'h0, 2'b00, 1'b1, 1'b0);
    @(negedge CLK);
    drive(mk(0,0,0,0,0, 0,0,0, 7,12, 0,0,0,0,0));
    #1;
    check("post_reset_busy", 32'h0, 32'h0, 2'b10, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
